// File: rtl/lane_serializer.sv
// Word-to-lane serializer: splits each DATA_IN_W word into RATIO slices, one per clk_4f cycle.
// Holds one active word and one pending word so that back-to-back words stream without gaps.
module lane_serializer #(
    parameter int                    DATA_IN_W  = 32,
    parameter int                    DATA_OUT_W = 8,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_OUT_W-1:0] IDLE_OUT   = '0
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [DATA_IN_W-1:0]  data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_OUT_W-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  o_dbg_state,
    output logic                  o_dbg_pend_full
);

    localparam int RATIO = DATA_IN_W / DATA_OUT_W;
    localparam int CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    generate
        if (RATIO < 2 || (DATA_IN_W % DATA_OUT_W) != 0) begin : g_bad_ratio
            $error("lane_serializer: DATA_IN_W must be an exact multiple (>=2) of DATA_OUT_W");
        end
    endgenerate

    // Handshake: a word is accepted on a clk_4f edge where valid_in && ready_out;
    // ready_out depends only on the pending slot, never on valid_in.
    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t                  r_state,     w_state_nxt;
    logic [CNT_W-1:0]        r_cnt,       w_cnt_nxt;
    logic [DATA_IN_W-1:0]    r_act,       w_act_nxt;
    logic [DATA_IN_W-1:0]    r_pend,      w_pend_nxt;
    logic                    r_pend_full, w_pend_full_nxt;
    logic [DATA_OUT_W-1:0]   r_data_out,  w_data_nxt;
    logic                    r_valid_out, w_valid_nxt;
    logic                    r_last_out,  w_last_nxt;
    logic                    w_slot_free;

    function automatic logic [DATA_OUT_W-1:0] slice_of(input logic [DATA_IN_W-1:0] word,
                                                       input logic [CNT_W-1:0]     idx);
        if (MSB_FIRST)
            slice_of = word[DATA_IN_W - 1 - int'(idx) * DATA_OUT_W -: DATA_OUT_W];
        else
            slice_of = word[int'(idx) * DATA_OUT_W +: DATA_OUT_W];
    endfunction

    // State register
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend_full <= 1'b0;
            r_data_out  <= IDLE_OUT;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_full <= w_pend_full_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_last_out  <= w_last_nxt;
        end
    end

    // Word storage carries no reset; pend_full/state decide whether its content is meaningful.
    always_ff @(posedge clk_4f) begin
        r_act  <= w_act_nxt;
        r_pend <= w_pend_nxt;
    end

    assign w_slot_free = (r_state == ST_IDLE) || (r_cnt == LAST_IDX);
    assign ready_out   = !r_pend_full;

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_act_nxt       = r_act;
        w_pend_nxt      = r_pend;
        w_pend_full_nxt = r_pend_full;
        if (w_slot_free) begin
            w_cnt_nxt = '0;
            if (r_pend_full) begin
                w_act_nxt       = r_pend;
                w_pend_full_nxt = 1'b0;
                w_state_nxt     = ST_SEND;
            end else if (valid_in) begin
                w_act_nxt   = data_in;
                w_state_nxt = ST_SEND;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (valid_in && !r_pend_full) begin
                w_pend_nxt      = data_in;
                w_pend_full_nxt = 1'b1;
            end
        end
    end

    // Output logic: registered outputs follow the slice selected by the next state
    always_comb begin
        w_data_nxt  = IDLE_OUT;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        if (w_state_nxt == ST_SEND) begin
            w_data_nxt  = slice_of(w_act_nxt, w_cnt_nxt);
            w_valid_nxt = 1'b1;
            w_last_nxt  = (w_cnt_nxt == LAST_IDX);
        end
    end

    assign data_out        = r_data_out;
    assign valid_out       = r_valid_out;
    assign last_out        = r_last_out;
    assign o_dbg_state     = r_state;
    assign o_dbg_pend_full = r_pend_full;

endmodule
